video_timing_gen: RTL and testbench

Parametrised successor to the fixed 8-bit/3-channel sync generator. Produces hsync/vsync/de timing for a programmable progressive raster, with separate H and V polarity, and NUM_CH x DATA_W pixel data. Also adds an upstream pixel-request handshake, frame/line markers, active-pixel coordinates, a sticky underflow flag and frame-boundary config shadowing. It sits between the frame-buffer read FIFO and the video output PHY/encoder.

---
 rtl/video_timing_pkg.sv | 19 +
 rtl/video_timing_axis_cnt.sv | 64 ++++++
 rtl/video_timing_gen.sv | 166 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared types and helpers for the video timing generator
package video_timing_pkg;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        BP     = 2'd1,
        ACTIVE = 2'd2,
        FP     = 2'd3
    } region_t;

    localparam logic POL_HIGH = 1'b1;
    localparam logic POL_LOW  = 1'b0;

    // Totals of sync+porches+active never overflow at two bits above the active width.
    function automatic int total_w(input int cnt_w);
        return cnt_w + 2;
    endfunction

endpackage

// File: rtl/video_timing_axis_cnt.sv
// rtl/video_timing_axis_cnt.sv - one raster axis: position counter, wrap and region decode
module video_timing_axis_cnt
    import video_timing_pkg::*;
#(
    parameter  int CNT_W   = 16,
    parameter  int PORCH_W = 12,
    parameter  int SYNC_W  = 8,
    localparam int TW      = total_w(CNT_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [SYNC_W-1:0]  sw,
    input  logic [PORCH_W-1:0] bp,
    input  logic [CNT_W-1:0]   active,
    input  logic [PORCH_W-1:0] fp,
    output logic [TW-1:0]      cnt,
    output logic               wrap,
    output region_t            region,
    output logic               in_active,
    output logic [CNT_W-1:0]   pos
);

    logic [TW-1:0] sw_len;
    logic [TW-1:0] act_start;
    logic [TW-1:0] fp_start;
    logic [TW-1:0] total;

    // A zero sync width is stretched to one so the sync region always exists.
    always_comb begin
        sw_len    = (sw == '0) ? TW'(1) : TW'(sw);
        act_start = sw_len + TW'(bp);
        fp_start  = act_start + TW'(active);
        total     = fp_start + TW'(fp);
    end

    assign wrap = en && (cnt == total - TW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + TW'(1);
        end
    end

    always_comb begin
        region = FP;
        if (cnt < sw_len) begin
            region = SYNC;
        end else if (cnt < act_start) begin
            region = BP;
        end else if (cnt < fp_start) begin
            region = ACTIVE;
        end
    end

    assign in_active = (region == ACTIVE);
    assign pos       = CNT_W'(cnt - act_start);

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - programmable progressive raster timing generator with pixel handshake
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_CH  = 3,
    parameter int CNT_W   = 16,
    parameter int PORCH_W = 12,
    parameter int SYNC_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sync_en,
    input  logic                     hpol_i,
    input  logic                     vpol_i,
    input  logic [CNT_W-1:0]         hactive_i,
    input  logic [CNT_W-1:0]         vactive_i,
    input  logic [PORCH_W-1:0]       hfp_i,
    input  logic [PORCH_W-1:0]       hbp_i,
    input  logic [PORCH_W-1:0]       vfp_i,
    input  logic [PORCH_W-1:0]       vbp_i,
    input  logic [SYNC_W-1:0]        hsw_i,
    input  logic [SYNC_W-1:0]        vsw_i,
    input  logic [NUM_CH*DATA_W-1:0] pix_data_i,
    input  logic                     pix_valid_i,
    output logic                     pix_req_o,
    output logic                     hsync_o,
    output logic                     vsync_o,
    output logic                     de_o,
    output logic [NUM_CH*DATA_W-1:0] pix_data_o,
    output logic [CNT_W-1:0]         hcnt_o,
    output logic [CNT_W-1:0]         vcnt_o,
    output logic                     frame_start_o,
    output logic                     line_start_o,
    output logic                     underflow_o,
    input  logic                     underflow_clr_i,
    output logic                     cfg_err_o
);

    localparam int TW = total_w(CNT_W);

    logic               sh_hpol, sh_vpol;
    logic [CNT_W-1:0]   sh_hact, sh_vact;
    logic [PORCH_W-1:0] sh_hfp, sh_hbp, sh_vfp, sh_vbp;
    logic [SYNC_W-1:0]  sh_hsw, sh_vsw;

    logic               en_q, cfg_ok, running, run_en, load;
    logic [TW-1:0]      h_cnt, v_cnt;
    logic               h_wrap, v_wrap, h_act, v_act;
    region_t            h_reg, v_reg;
    logic [CNT_W-1:0]   h_pos, v_pos;

    assign cfg_ok  = (sh_hact != '0) && (sh_vact != '0);
    assign running = en_q && cfg_ok;
    assign run_en  = sync_en && running;
    // Reload on enable edge, on every cycle while the held config is invalid, and at frame end.
    assign load    = sync_en && (!en_q || !cfg_ok || v_wrap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            cfg_err_o <= 1'b0;
            sh_hpol   <= 1'b0;
            sh_vpol   <= 1'b0;
            sh_hact   <= '0;
            sh_vact   <= '0;
            sh_hfp    <= '0;
            sh_hbp    <= '0;
            sh_vfp    <= '0;
            sh_vbp    <= '0;
            sh_hsw    <= '0;
            sh_vsw    <= '0;
        end else begin
            en_q <= sync_en;
            if (load) begin
                cfg_err_o <= (hactive_i == '0) || (vactive_i == '0);
                sh_hpol   <= hpol_i;
                sh_vpol   <= vpol_i;
                sh_hact   <= hactive_i;
                sh_vact   <= vactive_i;
                sh_hfp    <= hfp_i;
                sh_hbp    <= hbp_i;
                sh_vfp    <= vfp_i;
                sh_vbp    <= vbp_i;
                sh_hsw    <= hsw_i;
                sh_vsw    <= vsw_i;
            end
        end
    end

    video_timing_axis_cnt #(
        .CNT_W   (CNT_W),
        .PORCH_W (PORCH_W),
        .SYNC_W  (SYNC_W)
    ) u_h (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (!run_en),
        .en        (run_en),
        .sw        (sh_hsw),
        .bp        (sh_hbp),
        .active    (sh_hact),
        .fp        (sh_hfp),
        .cnt       (h_cnt),
        .wrap      (h_wrap),
        .region    (h_reg),
        .in_active (h_act),
        .pos       (h_pos)
    );

    video_timing_axis_cnt #(
        .CNT_W   (CNT_W),
        .PORCH_W (PORCH_W),
        .SYNC_W  (SYNC_W)
    ) u_v (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (!run_en),
        .en        (h_wrap),
        .sw        (sh_vsw),
        .bp        (sh_vbp),
        .active    (sh_vact),
        .fp        (sh_vfp),
        .cnt       (v_cnt),
        .wrap      (v_wrap),
        .region    (v_reg),
        .in_active (v_act),
        .pos       (v_pos)
    );

    assign pix_req_o = run_en && h_act && v_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_o       <= 1'b1;
            vsync_o       <= 1'b1;
            de_o          <= 1'b0;
            pix_data_o    <= '0;
            hcnt_o        <= '0;
            vcnt_o        <= '0;
            frame_start_o <= 1'b0;
            line_start_o  <= 1'b0;
            underflow_o   <= 1'b0;
        end else begin
            if (run_en) begin
                hsync_o <= (sh_hpol == POL_HIGH) ? (h_reg == SYNC) : (h_reg != SYNC);
                vsync_o <= (sh_vpol == POL_HIGH) ? (v_reg == SYNC) : (v_reg != SYNC);
            end else begin
                hsync_o <= (hpol_i == POL_LOW);
                vsync_o <= (vpol_i == POL_LOW);
            end
            de_o          <= pix_req_o;
            pix_data_o    <= (pix_req_o && pix_valid_i) ? pix_data_i : '0;
            hcnt_o        <= pix_req_o ? h_pos : '0;
            vcnt_o        <= pix_req_o ? v_pos : '0;
            line_start_o  <= run_en && (h_cnt == '0);
            frame_start_o <= run_en && (h_cnt == '0) && (v_cnt == '0);
            if (pix_req_o && !pix_valid_i) begin
                underflow_o <= 1'b1;
            end else if (underflow_clr_i) begin
                underflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen
module tb_video_timing_gen;

    localparam int CW = 16;
    localparam int PWD = 12;
    localparam int SWD = 8;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sync_en = 1'b0;
    logic hpol_i = 1'b1, vpol_i = 1'b1;
    logic [CW-1:0] hactive_i = '0, vactive_i = '0;
    logic [PWD-1:0] hfp_i = '0, hbp_i = '0, vfp_i = '0, vbp_i = '0;
    logic [SWD-1:0] hsw_i = '0, vsw_i = '0;
    logic [DW-1:0] pix_data_i = '0;
    logic pix_valid_i = 1'b1;
    logic pix_req_o, hsync_o, vsync_o, de_o;
    logic [DW-1:0] pix_data_o;
    logic [CW-1:0] hcnt_o, vcnt_o;
    logic frame_start_o, line_start_o, underflow_o, cfg_err_o;
    logic underflow_clr_i = 1'b0;

    always #5 clk = ~clk;

    video_timing_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sync_en         (sync_en),
        .hpol_i          (hpol_i),
        .vpol_i          (vpol_i),
        .hactive_i       (hactive_i),
        .vactive_i       (vactive_i),
        .hfp_i           (hfp_i),
        .hbp_i           (hbp_i),
        .vfp_i           (vfp_i),
        .vbp_i           (vbp_i),
        .hsw_i           (hsw_i),
        .vsw_i           (vsw_i),
        .pix_data_i      (pix_data_i),
        .pix_valid_i     (pix_valid_i),
        .pix_req_o       (pix_req_o),
        .hsync_o         (hsync_o),
        .vsync_o         (vsync_o),
        .de_o            (de_o),
        .pix_data_o      (pix_data_o),
        .hcnt_o          (hcnt_o),
        .vcnt_o          (vcnt_o),
        .frame_start_o   (frame_start_o),
        .line_start_o    (line_start_o),
        .underflow_o     (underflow_o),
        .underflow_clr_i (underflow_clr_i),
        .cfg_err_o       (cfg_err_o)
    );

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic          fs;
        logic          ls;
        logic [CW-1:0] hc;
        logic [CW-1:0] vc;
    } obs_t;

    obs_t obs;
    assign obs = {hsync_o, vsync_o, de_o, frame_start_o, line_start_o, hcnt_o, vcnt_o};

    obs_t          exp_q[$];
    logic [DW-1:0] data_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic set_cfg(input int hact);
        hactive_i = CW'(hact); vactive_i = 16'd3;
        hsw_i = 8'd2; hbp_i = 12'd2; hfp_i = 12'd2;
        vsw_i = 8'd1; vbp_i = 12'd1; vfp_i = 12'd1;
    endtask

    // Reference raster built directly from the line/frame layout.
    task automatic gen_frame(input int hact, input int hsw, input int hbp, input int hfp,
                             input int vact, input int vsw, input int vbp, input int vfp,
                             input logic pol);
        int ht = hsw + hbp + hact + hfp;
        int vt = vsw + vbp + vact + vfp;
        for (int v = 0; v < vt; v++) begin
            for (int h = 0; h < ht; h++) begin
                obs_t e;
                logic a;
                a = (h >= hsw + hbp) && (h < hsw + hbp + hact) &&
                    (v >= vsw + vbp) && (v < vsw + vbp + vact);
                e.hs = (h < hsw) ? pol : !pol;
                e.vs = (v < vsw) ? pol : !pol;
                e.de = a;
                e.fs = (h == 0) && (v == 0);
                e.ls = (h == 0);
                e.hc = a ? CW'(h - hsw - hbp) : '0;
                e.vc = a ? CW'(v - vsw - vbp) : '0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sync_en = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({hsync_o, vsync_o} !== 2'b11) begin
            n_fail++; $display("FAIL reset_syncs got %b want 11", {hsync_o, vsync_o});
        end
        n_checks++;
        if ({de_o, pix_req_o, frame_start_o, line_start_o, underflow_o, cfg_err_o} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags got %b want 000000",
                {de_o, pix_req_o, frame_start_o, line_start_o, underflow_o, cfg_err_o});
        end
        n_checks++;
        if ({pix_data_o, hcnt_o, vcnt_o} !== '0) begin
            n_fail++; $display("FAIL reset_data got %h/%0d/%0d want 0/0/0", pix_data_o, hcnt_o, vcnt_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_raster(input logic pol);
        logic prev_req;
        int de_cnt = 0, hs_on = 0, vs_on = 0, fs_cnt = 0, fs_first = -1, fs_second = -1;
        sync_en = 1'b0;
        set_cfg(4);
        hpol_i = pol; vpol_i = pol;
        pix_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete(); data_q.delete();
        sync_en = 1'b1;
        #1 prev_req = pix_req_o;
        @(negedge clk);
        n_checks++;
        if (hsync_o !== !pol || frame_start_o !== 1'b0 || de_o !== 1'b0) begin
            n_fail++; $display("FAIL raster_idle_pol%0b got hs=%b fs=%b de=%b want hs=%b fs=0 de=0",
                pol, hsync_o, frame_start_o, de_o, !pol);
        end
        pix_data_i = pix_data_i + 1'b1;
        #1 prev_req = pix_req_o;
        if (prev_req) data_q.push_back(pix_data_i);
        gen_frame(4, 2, 2, 2, 3, 1, 1, 1, pol);
        gen_frame(4, 2, 2, 2, 3, 1, 1, 1, pol);
        for (int c = 0; c < 120; c++) begin
            obs_t e;
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL raster_stream_pol%0b cyc %0d got %h want %h", pol, c, obs, e);
            end
            n_checks++;
            if (de_o !== prev_req) begin
                n_fail++; $display("FAIL de_latency cyc %0d got de=%b want %b", c, de_o, prev_req);
            end
            if (de_o) begin
                n_checks++;
                if (data_q.size() == 0) begin
                    n_fail++; $display("FAIL pix_data cyc %0d got %h want none queued", c, pix_data_o);
                end else begin
                    logic [DW-1:0] d;
                    d = data_q.pop_front();
                    if (pix_data_o !== d) begin
                        n_fail++; $display("FAIL pix_data cyc %0d got %h want %h", c, pix_data_o, d);
                    end
                end
            end
            de_cnt += int'(de_o);
            hs_on  += int'(hsync_o === pol);
            vs_on  += int'(vsync_o === pol);
            if (frame_start_o) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = c; else fs_second = c;
            end
            pix_data_i = pix_data_i + 1'b1;
            #1 prev_req = pix_req_o;
            if (prev_req) data_q.push_back(pix_data_i);
        end
        n_checks++;
        if (de_cnt != 24) begin
            n_fail++; $display("FAIL de_pixels_pol%0b got %0d want 24", pol, de_cnt);
        end
        n_checks++;
        if (hs_on != 24 || vs_on != 20) begin
            n_fail++; $display("FAIL sync_counts_pol%0b got hs=%0d vs=%0d want 24/20", pol, hs_on, vs_on);
        end
        n_checks++;
        if (fs_cnt != 2 || fs_second - fs_first != 60) begin
            n_fail++; $display("FAIL frame_period_pol%0b got n=%0d gap=%0d want 2/60",
                pol, fs_cnt, fs_second - fs_first);
        end
        sync_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_polarity();
        test_raster(1'b0);
        hpol_i = 1'b1; vpol_i = 1'b1;
    endtask

    task automatic test_underflow();
        logic found;
        sync_en = 1'b0;
        set_cfg(4);
        pix_valid_i = 1'b1;
        underflow_clr_i = 1'b1;
        @(negedge clk);
        underflow_clr_i = 1'b0;
        @(negedge clk);
        sync_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk); #1;
            if (pix_req_o) found = 1'b1;
        end
        n_checks++;
        if (!found || underflow_o !== 1'b0) begin
            n_fail++; $display("FAIL uf_pre got req=%b uf=%b want 1/0", found, underflow_o);
        end
        pix_valid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pix_data_o !== '0 || underflow_o !== 1'b1 || de_o !== 1'b1) begin
            n_fail++; $display("FAIL uf_set got data=%h uf=%b de=%b want 0/1/1", pix_data_o, underflow_o, de_o);
        end
        pix_valid_i = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (underflow_o !== 1'b1) begin
            n_fail++; $display("FAIL uf_sticky got %b want 1", underflow_o);
        end
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk); #1;
            if (pix_req_o) found = 1'b1;
        end
        pix_valid_i = 1'b0;
        underflow_clr_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (!found || underflow_o !== 1'b1) begin
            n_fail++; $display("FAIL uf_set_wins got req=%b uf=%b want 1/1", found, underflow_o);
        end
        pix_valid_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (underflow_o !== 1'b0) begin
            n_fail++; $display("FAIL uf_clear got %b want 0", underflow_o);
        end
        underflow_clr_i = 1'b0;
        sync_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_shadow();
        logic found;
        int fidx = 0, start1 = 0, run = 0;
        int len[2], dc[2], maxrun[2], lines0;
        len = '{0, 0}; dc = '{0, 0}; maxrun = '{0, 0}; lines0 = 0;
        sync_en = 1'b0;
        set_cfg(4);
        repeat (2) @(negedge clk);
        sync_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (frame_start_o) found = 1'b1;
        end
        lines0 = 1;
        for (int i = 1; i < 300; i++) begin
            @(negedge clk);
            if (frame_start_o) begin
                if (fidx == 0) begin
                    len[0] = i; start1 = i; fidx = 1;
                end else begin
                    len[1] = i - start1;
                    break;
                end
            end
            if (line_start_o && fidx == 0) lines0++;
            if (de_o) begin
                dc[fidx]++; run++;
                if (run > maxrun[fidx]) maxrun[fidx] = run;
            end else begin
                run = 0;
            end
            if (i == 20) hactive_i = 16'd6;
        end
        n_checks++;
        if (!found || len[0] != 60 || dc[0] != 12 || maxrun[0] != 4 || lines0 != 6) begin
            n_fail++; $display("FAIL shadow_frame0 got len=%0d de=%0d run=%0d lines=%0d want 60/12/4/6",
                len[0], dc[0], maxrun[0], lines0);
        end
        n_checks++;
        if (len[1] != 72 || dc[1] != 18 || maxrun[1] != 6) begin
            n_fail++; $display("FAIL shadow_frame1 got len=%0d de=%0d run=%0d want 72/18/6",
                len[1], dc[1], maxrun[1]);
        end
        sync_en = 1'b0;
        hactive_i = 16'd4;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_disable_error();
        logic found;
        int de_seen = 0;
        sync_en = 1'b0;
        set_cfg(4);
        hpol_i = 1'b1; vpol_i = 1'b1;
        repeat (2) @(negedge clk);
        sync_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (de_o) found = 1'b1;
        end
        sync_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!found || de_o !== 1'b0 || hsync_o !== 1'b0 || vsync_o !== 1'b0 || pix_req_o !== 1'b0) begin
            n_fail++; $display("FAIL disable got found=%b de=%b hs=%b vs=%b req=%b want 1/0/0/0/0",
                found, de_o, hsync_o, vsync_o, pix_req_o);
        end
        hactive_i = '0;
        @(negedge clk);
        sync_en = 1'b1;
        repeat (80) begin
            @(negedge clk);
            de_seen += int'(de_o);
        end
        n_checks++;
        if (cfg_err_o !== 1'b1 || de_seen != 0) begin
            n_fail++; $display("FAIL cfg_err got err=%b de_cycles=%0d want 1/0", cfg_err_o, de_seen);
        end
        hactive_i = 16'd4;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (frame_start_o) found = 1'b1;
        end
        n_checks++;
        if (!found || cfg_err_o !== 1'b0) begin
            n_fail++; $display("FAIL cfg_retry got fs=%b err=%b want 1/0", found, cfg_err_o);
        end
        repeat (25) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({hsync_o, vsync_o, de_o, pix_req_o, frame_start_o, line_start_o, underflow_o, cfg_err_o}
                !== 8'b1100_0000 || {pix_data_o, hcnt_o, vcnt_o} !== '0) begin
            n_fail++; $display("FAIL async_reset got %b data=%h h=%0d v=%0d want 11000000 data=0 h=0 v=0",
                {hsync_o, vsync_o, de_o, pix_req_o, frame_start_o, line_start_o, underflow_o, cfg_err_o},
                pix_data_o, hcnt_o, vcnt_o);
        end
        sync_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_raster(1'b1);
        test_polarity();
        test_underflow();
        test_shadow();
        test_disable_error();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
